// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode of the incoming
// instruction feeding a two-entry (main + skid) valid/ready output buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHIFT = 3'd5;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_IMM32   = 7'b0011011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_REG32   = 7'b0111011;

    localparam logic             IS_RV64 = (XLEN == 32'sd64);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_ill_s;
    logic             is_shift_s;
    logic             accept_s;
    logic             drain_s;

    logic             main_valid_r;
    logic [XLEN-1:0]  main_imm_r;
    logic [2:0]       main_fmt_r;
    logic             main_ill_r;
    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [2:0]       skid_fmt_r;
    logic             skid_ill_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] illegal_cnt_r;

    // Instruction decode: format, illegal flag and XLEN-wide immediate.
    always_comb begin
        dec_imm_s  = {XLEN{1'b0}};
        dec_fmt_s  = FMT_NONE;
        dec_ill_s  = 1'b0;
        is_shift_s = (in_inst[14:12] == 3'b001) || (in_inst[14:12] == 3'b101);
        case (in_inst[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_fmt_s = FMT_I;
                dec_imm_s = XLEN'($signed(in_inst[31:20]));
            end
            OP_IMM: begin
                if (is_shift_s) begin
                    dec_fmt_s = FMT_SHIFT;
                    // shamt[5] only exists on RV64; inst[30] selects arithmetic shift
                    if (IS_RV64) begin
                        dec_imm_s = XLEN'(in_inst[25:20]);
                    end else begin
                        dec_imm_s = XLEN'(in_inst[24:20]);
                    end
                end else begin
                    dec_fmt_s = FMT_I;
                    dec_imm_s = XLEN'($signed(in_inst[31:20]));
                end
            end
            OP_IMM32: begin
                if (!IS_RV64) begin
                    dec_ill_s = 1'b1;
                end else if (is_shift_s) begin
                    dec_fmt_s = FMT_SHIFT;
                    dec_imm_s = XLEN'(in_inst[24:20]);
                end else begin
                    dec_fmt_s = FMT_I;
                    dec_imm_s = XLEN'($signed(in_inst[31:20]));
                end
            end
            OP_STORE: begin
                dec_fmt_s = FMT_S;
                dec_imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            OP_BRANCH: begin
                dec_fmt_s = FMT_B;
                dec_imm_s = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                           in_inst[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt_s = FMT_U;
                dec_imm_s = XLEN'($signed({in_inst[31:12], 12'd0}));
            end
            OP_JAL: begin
                dec_fmt_s = FMT_J;
                dec_imm_s = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                           in_inst[30:21], 1'b0}));
            end
            OP_REG: begin
                dec_ill_s = 1'b0;
            end
            OP_REG32: begin
                dec_ill_s = !IS_RV64;
            end
            default: begin
                dec_ill_s = 1'b1;
            end
        endcase
    end

    // Handshake qualifiers for this cycle.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        drain_s  = main_valid_r && out_ready;
    end

    // Main/skid buffer, registered ready and saturating illegal counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_r  <= 1'b0;
            main_imm_r    <= {XLEN{1'b0}};
            main_fmt_r    <= FMT_NONE;
            main_ill_r    <= 1'b0;
            skid_valid_r  <= 1'b0;
            skid_imm_r    <= {XLEN{1'b0}};
            skid_fmt_r    <= FMT_NONE;
            skid_ill_r    <= 1'b0;
            in_ready_r    <= 1'b1;
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            if (accept_s && dec_ill_s && (illegal_cnt_r != CNT_MAX)) begin
                illegal_cnt_r <= illegal_cnt_r + CNT_W'(1);
            end
            if (!main_valid_r) begin
                if (accept_s) begin
                    main_valid_r <= 1'b1;
                    main_imm_r   <= dec_imm_s;
                    main_fmt_r   <= dec_fmt_s;
                    main_ill_r   <= dec_ill_s;
                end
            end else if (skid_valid_r) begin
                // full: in_ready is low, so only a drain can change state
                if (drain_s) begin
                    main_imm_r   <= skid_imm_r;
                    main_fmt_r   <= skid_fmt_r;
                    main_ill_r   <= skid_ill_r;
                    skid_valid_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                end
            end else if (drain_s && accept_s) begin
                main_imm_r <= dec_imm_s;
                main_fmt_r <= dec_fmt_s;
                main_ill_r <= dec_ill_s;
            end else if (drain_s) begin
                main_valid_r <= 1'b0;
            end else if (accept_s) begin
                skid_valid_r <= 1'b1;
                skid_imm_r   <= dec_imm_s;
                skid_fmt_r   <= dec_fmt_s;
                skid_ill_r   <= dec_ill_s;
                in_ready_r   <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = main_valid_r;
    assign out_imm     = main_imm_r;
    assign out_fmt     = main_fmt_r;
    assign out_illegal = main_ill_r;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances share stimulus and are
// checked every cycle against a queue-based reference model plus directed vectors.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_imm;
    logic [2:0]  r32_out_fmt;
    logic [1:0]  r32_cnt;
    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [63:0] r64_out_imm;
    logic [2:0]  r64_out_fmt;
    logic [1:0]  r64_cnt;

    ent_t        q32[$];
    ent_t        q64[$];
    logic [31:0] seen[$];
    int          cnt32, cnt64;
    bit          armed = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(r32_in_ready), .in_inst(in_inst), .out_valid(r32_out_valid),
        .out_ready(out_ready), .out_imm(r32_out_imm), .out_fmt(r32_out_fmt),
        .out_illegal(r32_out_illegal), .illegal_cnt(r32_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(r64_in_ready), .in_inst(in_inst), .out_valid(r64_out_valid),
        .out_ready(out_ready), .out_imm(r64_out_imm), .out_fmt(r64_out_fmt),
        .out_illegal(r64_out_illegal), .illegal_cnt(r64_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement interpretation of a 'bits'-wide field.
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic [63:0] r;
        r = v;
        if (v[bits-1]) r = v - (64'd1 << bits);
        return r;
    endfunction

    function automatic ent_t ref_dec(input logic [31:0] inst, input int xlen);
        ent_t e;
        bit   sh;
        sh    = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
        e.imm = 64'd0;
        e.fmt = 3'd7;
        e.ill = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b1100111, 7'b1110011: begin
                e.fmt = 3'd0; e.imm = sx(64'(inst[31:20]), 12);
            end
            7'b0010011, 7'b0011011: begin
                if (inst[6:0] == 7'b0011011 && xlen == 32) e.ill = 1'b1;
                else if (sh) begin
                    e.fmt = 3'd5;
                    e.imm = 64'(inst >> 20) % ((xlen == 64 && inst[6:0] == 7'b0010011) ? 64'd64 : 64'd32);
                end else begin
                    e.fmt = 3'd0; e.imm = sx(64'(inst[31:20]), 12);
                end
            end
            7'b0100011: begin e.fmt = 3'd1; e.imm = sx(64'({inst[31:25], inst[11:7]}), 12); end
            7'b1100011: begin
                e.fmt = 3'd2;
                e.imm = sx(64'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 64'd2, 13);
            end
            7'b0110111, 7'b0010111: begin e.fmt = 3'd3; e.imm = sx(64'(inst[31:12]) * 64'd4096, 32); end
            7'b1101111: begin
                e.fmt = 3'd4;
                e.imm = sx(64'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 64'd2, 21);
            end
            7'b0110011: e.ill = 1'b0;
            7'b0111011: e.ill = (xlen == 32);
            default:    e.ill = 1'b1;
        endcase
        if (xlen == 32) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
        return e;
    endfunction

    // Reference model: occupancy queue updated at every rising edge.
    always @(posedge clk) begin : model
        bit do_pop, do_push;
        ent_t e32, e64;
        if (!rst_n) begin
            q32.delete(); q64.delete();
            cnt32 <= 0; cnt64 <= 0;
            armed <= 1'b1;
        end else if (flush) begin
            q32.delete(); q64.delete();
        end else if (armed) begin
            do_pop  = (q32.size() > 0) && out_ready;
            do_push = in_valid && (q32.size() < 2);
            if (do_pop) begin
                seen.push_back(r32_out_imm);
                void'(q32.pop_front()); void'(q64.pop_front());
            end
            if (do_push) begin
                e32 = ref_dec(in_inst, 32);
                e64 = ref_dec(in_inst, 64);
                q32.push_back(e32); q64.push_back(e64);
                if (e32.ill && cnt32 < 3) cnt32 <= cnt32 + 1;
                if (e64.ill && cnt64 < 3) cnt64 <= cnt64 + 1;
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("valid32", 64'(r32_out_valid), 64'(q32.size() > 0));
            chk("ready32", 64'(r32_in_ready), 64'(q32.size() < 2));
            chk("cnt32", 64'(r32_cnt), 64'(cnt32));
            chk("valid64", 64'(r64_out_valid), 64'(q64.size() > 0));
            chk("ready64", 64'(r64_in_ready), 64'(q64.size() < 2));
            chk("cnt64", 64'(r64_cnt), 64'(cnt64));
            if (q32.size() > 0 && r32_out_valid) begin
                chk("imm32", 64'(r32_out_imm), q32[0].imm);
                chk("fmt32", 64'(r32_out_fmt), 64'(q32[0].fmt));
                chk("ill32", 64'(r32_out_illegal), 64'(q32[0].ill));
            end
            if (q64.size() > 0 && r64_out_valid) begin
                chk("imm64", r64_out_imm, q64[0].imm);
                chk("fmt64", 64'(r64_out_fmt), 64'(q64[0].fmt));
                chk("ill64", 64'(r64_out_illegal), 64'(q64[0].ill));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] e32, input logic [63:0] e64,
                        input logic [2:0] fmt, input logic ill);
        in_inst = inst; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_valid", 64'(r32_out_valid), 64'd1);
        chk("lit_imm32", 64'(r32_out_imm), 64'(e32));
        chk("lit_imm64", r64_out_imm, e64);
        chk("lit_fmt", 64'(r32_out_fmt), 64'(fmt));
        chk("lit_ill", 64'(r32_out_illegal), 64'(ill));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [31:0] w;
        int k;
        ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011};
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 12) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin : stim
        ent_t p;
        bit   acc;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = 32'd0;
        tick; tick;
        @(negedge clk);
        chk("rst_valid", 64'(r32_out_valid), 64'd0);
        chk("rst_imm", 64'(r32_out_imm), 64'd0);
        chk("rst_fmt", 64'(r32_out_fmt), 64'd7);
        chk("rst_ill", 64'(r32_out_illegal), 64'd0);
        chk("rst_cnt", 64'(r32_cnt), 64'd0);
        chk("rst_ready", 64'(r32_in_ready), 64'd1);
        tick;
        rst_n = 1'b1;

        p = ref_dec(32'hFE000EE3, 32); chk("pin_beq", p.imm, 64'h0000_0000_FFFF_FFFC);
        p = ref_dec(32'h4230D093, 64); chk("pin_srai64", p.imm, 64'd35);
        p = ref_dec(32'hFF9FF06F, 64); chk("pin_jal64", p.imm, 64'hFFFF_FFFF_FFFF_FFF8);

        send(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
        send(32'h123450B7, 32'h12345000, 64'h0000_0000_1234_5000, 3'd3, 1'b0);
        send(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        send(32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFF_FFFF_FFFF_FFF8, 3'd4, 1'b0);
        send(32'h4030D093, 32'd3, 64'd3, 3'd5, 1'b0);
        send(32'h4230D093, 32'd3, 64'd35, 3'd5, 1'b0);

        // illegal counter saturation at CNT_W=2
        tick; do_reset;
        for (int i = 0; i < 6; i++) begin
            send(32'h00000000, 32'd0, 64'd0, 3'd7, 1'b1);
            chk("sat_cnt", 64'(r32_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
        end

        // back-pressure: three inputs, two held, third stalls upstream
        tick; do_reset; seen.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093;
        tick; in_inst = 32'h00200093;
        tick; in_inst = 32'h00300093;
        @(negedge clk);
        chk("bp_ready", 64'(r32_in_ready), 64'd0);
        chk("bp_head", 64'(r32_out_imm), 64'd1);
        tick;
        @(negedge clk);
        chk("bp_hold", 64'(r32_in_ready), 64'd0);
        tick;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            if (r32_in_ready) acc = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        if (!acc) chk("bp_timeout", 64'd0, 64'd1);
        tick; tick; tick;
        chk("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            chk("bp_ord0", 64'(seen[0]), 64'd1);
            chk("bp_ord1", 64'(seen[1]), 64'd2);
            chk("bp_ord2", 64'(seen[2]), 64'd3);
        end

        // flush with two held plus a new offer
        do_reset; seen.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000000;
        tick; tick;
        in_inst = 32'h00500093; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_valid", 64'(r32_out_valid), 64'd0);
        chk("fl_ready", 64'(r32_in_ready), 64'd1);
        chk("fl_cnt", 64'(r32_cnt), 64'd2);
        out_ready = 1'b1;
        tick; tick; tick;
        chk("fl_none", 64'(seen.size()), 64'd0);

        // same scenario ended by reset
        seen.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000000;
        tick; tick;
        in_inst = 32'h00500093; rst_n = 1'b0;
        tick;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rs_valid", 64'(r32_out_valid), 64'd0);
        chk("rs_ready", 64'(r32_in_ready), 64'd1);
        chk("rs_cnt", 64'(r32_cnt), 64'd0);
        out_ready = 1'b1;
        tick; tick; tick;
        chk("rs_none", 64'(seen.size()), 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick;
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick; tick; tick;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
